// File: rtl/motor_pkg.sv
// Shared constants and state encodings for the motor command sequencer.
// Both FSM state types are also exported through the top's debug ports.
package motor_pkg;

  localparam logic [7:0] HDR      = 8'hA5;
  localparam logic [7:0] ACK_OK   = 8'h41;
  localparam logic [7:0] ACK_BAD  = 8'h4E;
  localparam logic [7:0] ACK_BUSY = 8'h42;

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} parser_state_t;
  typedef enum logic       {IDLE, RUN}            exec_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO with first-word fall-through read data and synchronous flush.
// Flush has priority over a push or pop issued in the same cycle.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// UART-framed motor command parser feeding a FIFO of timed H-bridge PWM commands.
// Each frame is acknowledged with one byte; the executor plays commands back to back.
module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int PWM_BITS  = 7,
  parameter int DUR_SHIFT = 22,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic                   stop,
  output logic [2*NCH-1:0]       hbridge,
  output logic                   busy,
  output logic                   cmd_done,
  output logic [$clog2(DEPTH):0] fifo_count,
  output parser_state_t          dbg_parser_state,
  output exec_state_t            dbg_exec_state
);

  localparam int FW    = 8 * (NCH + 1);
  localparam int IDX_W = $clog2(NCH + 1);
  localparam int RUN_W = 8 + DUR_SHIFT;

  // Both byte streams use valid/ready: a transfer happens on a cycle where both are high,
  // and the source holds its data stable while valid is high and ready is low.
  parser_state_t        ps_q, ps_d;
  logic [IDX_W-1:0]     idx_q;
  logic [7:0]           csum_q;
  logic [NCH:0][7:0]    pl_q;
  logic                 push_q;
  logic                 rx_fire;

  exec_state_t          ex_q, ex_d;
  logic                 pop, load, done_d;
  logic                 fifo_full, fifo_empty;
  logic [FW-1:0]        fifo_dout;
  logic [7:0]           dur_in;
  logic [8*NCH-1:0]     mot_q;
  logic [RUN_W-1:0]     rem_q;
  logic [PWM_BITS-1:0]  pwm_q;

  assign rx_ready         = ~tx_valid;
  assign rx_fire          = rx_valid && rx_ready;
  assign busy             = (ex_q == RUN);
  assign dur_in           = fifo_dout[8*NCH +: 8];
  assign dbg_parser_state = ps_q;
  assign dbg_exec_state   = ex_q;

  always_comb begin
    ps_d = ps_q;
    if (rx_fire) begin
      case (ps_q)
        HUNT:    if (rx_data == HDR) ps_d = PAYLOAD;
        PAYLOAD: if (idx_q == IDX_W'(NCH)) ps_d = CHECK;
        CHECK:   ps_d = HUNT;
        default: ps_d = HUNT;
      endcase
    end
  end

  // The push fires the cycle after the checksum byte, alongside the rising ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q     <= HUNT;
      idx_q    <= '0;
      csum_q   <= '0;
      pl_q     <= '0;
      push_q   <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      ps_q   <= ps_d;
      push_q <= 1'b0;
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (rx_fire) begin
        case (ps_q)
          HUNT: begin
            idx_q  <= '0;
            csum_q <= '0;
          end
          PAYLOAD: begin
            pl_q[idx_q] <= rx_data;
            csum_q      <= csum_q ^ rx_data;
            idx_q       <= idx_q + IDX_W'(1);
          end
          CHECK: begin
            tx_valid <= 1'b1;
            if (rx_data != csum_q) begin
              tx_data <= ACK_BAD;
            end else if (fifo_full) begin
              tx_data <= ACK_BUSY;
            end else begin
              tx_data <= ACK_OK;
              push_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .din   (pl_q),
    .pop   (pop),
    .dout  (fifo_dout),
    .flush (stop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    ex_d   = ex_q;
    pop    = 1'b0;
    load   = 1'b0;
    done_d = 1'b0;
    if (stop) begin
      ex_d = IDLE;
    end else begin
      case (ex_q)
        IDLE: if (!fifo_empty) begin
          pop  = 1'b1;
          load = 1'b1;
          if (dur_in != 8'h00) ex_d = RUN;
          else                 done_d = 1'b1;
        end
        RUN: if (rem_q == '0) begin
          ex_d   = IDLE;
          done_d = 1'b1;
        end
        default: ex_d = IDLE;
      endcase
    end
  end

  // rem_q holds remaining RUN cycles minus one, so the final cycle sees zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q     <= IDLE;
      cmd_done <= 1'b0;
      mot_q    <= '0;
      rem_q    <= '0;
      pwm_q    <= '0;
    end else begin
      ex_q     <= ex_d;
      cmd_done <= done_d;
      if (load) begin
        mot_q <= fifo_dout[8*NCH-1:0];
        rem_q <= (RUN_W'(dur_in) << DUR_SHIFT) - RUN_W'(1);
        pwm_q <= '0;
      end else if (ex_q == RUN) begin
        rem_q <= rem_q - RUN_W'(1);
        pwm_q <= pwm_q + PWM_BITS'(1);
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [PWM_BITS-1:0] mag;
    logic                wave;
    if (PWM_BITS >= 7) begin : g_up
      assign mag = PWM_BITS'(mot_q[8*i +: 7]) << (PWM_BITS - 7);
    end else begin : g_dn
      assign mag = PWM_BITS'(mot_q[8*i +: 7] >> (7 - PWM_BITS));
    end
    assign wave               = busy && (mag > pwm_q);
    assign hbridge[2*i +: 2]  = mot_q[8*i+7] ? {1'b0, wave} : {wave, 1'b0};
  end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed bench for motor_cmd_sequencer with NCH=2, PWM_BITS=7, DUR_SHIFT=2, DEPTH=4.
// Acks are checked against a queue of hand-written expected bytes.
module tb_motor_cmd_sequencer;
  import motor_pkg::*;

  localparam int NCH = 2, PWM_BITS = 7, DUR_SHIFT = 2, DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [7:0]             rx_data = 8'h00;
  logic                   rx_valid = 1'b0;
  logic                   rx_ready;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready = 1'b1;
  logic                   stop = 1'b0;
  logic [2*NCH-1:0]       hbridge;
  logic                   busy;
  logic                   cmd_done;
  logic [$clog2(DEPTH):0] fifo_count;
  parser_state_t          dbg_parser_state;
  exec_state_t            dbg_exec_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  motor_cmd_sequencer #(
    .NCH (NCH), .PWM_BITS (PWM_BITS), .DUR_SHIFT (DUR_SHIFT), .DEPTH (DEPTH)
  ) dut (
    .clk (clk), .reset (reset),
    .rx_data (rx_data), .rx_valid (rx_valid), .rx_ready (rx_ready),
    .tx_data (tx_data), .tx_valid (tx_valid), .tx_ready (tx_ready),
    .stop (stop), .hbridge (hbridge), .busy (busy), .cmd_done (cmd_done),
    .fifo_count (fifo_count),
    .dbg_parser_state (dbg_parser_state), .dbg_exec_state (dbg_exec_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (rx_ready !== 1'b1) chk("rx_ready_timeout", rx_ready, 1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] m0, input logic [7:0] m1,
                            input logic [7:0] dur, input logic [7:0] cs);
    send_byte(HDR);
    send_byte(m0);
    send_byte(m1);
    send_byte(dur);
    send_byte(cs);
  endtask

  task automatic check_ack(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    chk({tag, "_valid"}, tx_valid, 1);
    chk(tag, tx_data, e);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    chk(tag, busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (cmd_done !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    chk(tag, cmd_done, 1);
  endtask

  initial begin
    int run, bad, hi0, hi1, lo, nb, nd, nh;
    logic [3:0] exp_hb;

    // Reset values
    step();
    step();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_hbridge", hbridge, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_parser", dbg_parser_state, HUNT);
    reset = 1'b1;
    step();

    // Good frame, dur=3 -> 12 RUN cycles
    exp_q.push_back(ACK_OK);
    send_frame(8'h40, 8'hC0, 8'h03, 8'h83);
    check_ack("good_ack");
    chk("good_count_before_push", fifo_count, 0);
    step();
    chk("good_tx_drop", tx_valid, 0);
    chk("good_count_after_push", fifo_count, 1);
    step();
    chk("good_busy", busy, 1);
    chk("good_popped", fifo_count, 0);
    run = 0;
    bad = 0;
    while (busy && run < 100) begin
      exp_hb = ((run % 128) < 64) ? 4'b0110 : 4'b0000;
      if (hbridge !== exp_hb) bad++;
      run++;
      step();
    end
    chk("good_run_len", run, 12);
    chk("good_hbridge", bad, 0);
    chk("good_done", cmd_done, 1);
    step();
    chk("good_done_pulse", cmd_done, 0);

    // Bad checksum
    exp_q.push_back(ACK_BAD);
    send_frame(8'h40, 8'hC0, 8'h03, 8'h00);
    check_ack("bad_ack");
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (fifo_count != 0 || busy) bad++;
    end
    chk("bad_no_push", bad, 0);

    // Garbage bytes then a frame whose ack is stalled 5 cycles
    send_byte(8'h00);
    send_byte(8'h11);
    chk("garbage_no_ack", tx_valid, 0);
    chk("garbage_hunt", dbg_parser_state, HUNT);
    tx_ready = 1'b0;
    exp_q.push_back(ACK_OK);
    send_frame(8'h40, 8'hC0, 8'h03, 8'h83);
    check_ack("stall_ack");
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rx_ready !== 1'b0 || tx_valid !== 1'b1 || tx_data !== ACK_OK) bad++;
    end
    chk("stall_hold", bad, 0);
    tx_ready = 1'b1;
    step();
    chk("stall_tx_drop", tx_valid, 0);
    chk("stall_rx_ready", rx_ready, 1);
    wait_done("stall_cmd_done");

    // dur=0 command: done pulse without RUN
    exp_q.push_back(ACK_OK);
    send_frame(8'h40, 8'hC0, 8'h00, 8'h80);
    check_ack("zero_ack");
    nb = 0; nd = 0; nh = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      nb += int'(busy);
      nd += int'(cmd_done);
      if (hbridge != 0) nh++;
    end
    chk("zero_busy", nb, 0);
    chk("zero_done_once", nd, 1);
    chk("zero_hbridge", nh, 0);

    // Long command: 50% duty, then fill FIFO to full
    exp_q.push_back(ACK_OK);
    send_frame(8'h40, 8'hC0, 8'hFF, 8'h7F);
    check_ack("long_ack");
    wait_busy("long_busy");
    hi0 = 0; hi1 = 0; lo = 0; bad = 0;
    for (int i = 0; i < 128; i++) begin
      exp_hb = (i < 64) ? 4'b0110 : 4'b0000;
      hi0 += int'(hbridge[1]);
      hi1 += int'(hbridge[2]);
      lo  += int'(hbridge[0]) + int'(hbridge[3]);
      if (hbridge !== exp_hb) bad++;
      step();
    end
    chk("duty_ch0", hi0, 64);
    chk("duty_ch1", hi1, 64);
    chk("duty_off_legs", lo, 0);
    chk("duty_model", bad, 0);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(k < 4 ? ACK_OK : ACK_BUSY);
      send_frame(8'h40, 8'hC0, 8'hFF, 8'h7F);
      check_ack("fill_ack");
    end
    step();
    chk("fill_count_4", fifo_count, 4);
    chk("fill_still_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_hbridge", hbridge, 0);
    chk("stop_flush", fifo_count, 0);
    chk("stop_no_done", cmd_done, 0);
    step();
    step();
    chk("stop_stays_idle", busy, 0);

    // Back-to-back commands, then stop at RUN cycle 5 with 2 queued
    exp_q.push_back(ACK_OK);
    send_frame(8'h40, 8'hC0, 8'h08, 8'h88);
    check_ack("b2b_ack0");
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ACK_OK);
      send_frame(8'h40, 8'hC0, 8'hFF, 8'h7F);
      check_ack("b2b_ack");
    end
    wait_done("b2b_first_done");
    chk("b2b_gap_idle", busy, 0);
    step();
    chk("b2b_next_run", busy, 1);
    chk("b2b_queued_2", fifo_count, 2);
    for (int i = 0; i < 4; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("midrun_stop_busy", busy, 0);
    chk("midrun_stop_hbridge", hbridge, 0);
    chk("midrun_stop_flush", fifo_count, 0);
    chk("midrun_stop_no_done", cmd_done, 0);
    nb = 0; nd = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      nb += int'(busy);
      nd += int'(cmd_done);
    end
    chk("after_stop_busy", nb, 0);
    chk("after_stop_done", nd, 0);

    // stop held high: parser still acks, push discarded
    stop = 1'b1;
    exp_q.push_back(ACK_OK);
    send_frame(8'h40, 8'hC0, 8'h03, 8'h83);
    check_ack("held_ack");
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (fifo_count != 0 || busy) bad++;
    end
    chk("held_empty_idle", bad, 0);
    stop = 1'b0;
    step();
    step();
    chk("held_release_idle", busy, 0);

    // Reset mid-run with a queued command and a partial frame
    exp_q.push_back(ACK_OK);
    send_frame(8'h40, 8'hC0, 8'hFF, 8'h7F);
    check_ack("rr_ack0");
    wait_busy("rr_busy");
    exp_q.push_back(ACK_OK);
    send_frame(8'h40, 8'hC0, 8'hFF, 8'h7F);
    check_ack("rr_ack1");
    step();
    chk("rr_queued", fifo_count, 1);
    send_byte(HDR);
    send_byte(8'h40);
    chk("rr_partial", dbg_parser_state, PAYLOAD);
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hbridge", hbridge, 0);
    chk("arst_fifo_count", fifo_count, 0);
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_tx_data", tx_data, 8'h00);
    chk("arst_rx_ready", rx_ready, 1);
    chk("arst_cmd_done", cmd_done, 0);
    chk("arst_parser", dbg_parser_state, HUNT);
    step();
    step();
    reset = 1'b1;
    step();
    exp_q.push_back(ACK_OK);
    send_frame(8'h40, 8'hC0, 8'h00, 8'h80);
    check_ack("post_reset_ack");
    wait_done("post_reset_done");
    chk("ack_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_cmd_sequencer.md
MOTOR_CMD_SEQUENCER -- requirements
Module: motor_cmd_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 2, number of motor channels (1..8).
REQ-002 SHALL have parameter PWM_BITS, default 7, PWM magnitude and counter width.
REQ-003 SHALL have parameter DUR_SHIFT, default 22, where run length = dur * 2^DUR_SHIFT clk cycles.
REQ-004 SHALL have parameter DEPTH, default 4, command FIFO depth (power of 2, >=2).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rx_data, input, 8, byte from UART receiver.
REQ-008 SHALL have port rx_valid, input, 1, rx_data valid; a byte is accepted when rx_valid & rx_ready.
REQ-009 SHALL have port rx_ready, output, 1, high unless an ack is pending.
REQ-010 SHALL have port tx_data, output, 8, ack byte to UART transmitter.
REQ-011 SHALL have port tx_valid, output, 1, ack pending; held until tx_ready.
REQ-012 SHALL have port tx_ready, input, 1, transmitter accepts tx_data.
REQ-013 SHALL have port stop, input, 1, abort current command and flush FIFO.
REQ-014 SHALL have port hbridge, output, 2*NCH, pair [2i+1:2i] drives channel i.
REQ-015 SHALL have ports busy (1, executor running), cmd_done (1, one-cycle pulse per completed command) and fifo_count ($clog2(DEPTH)+1, occupancy), all outputs.

Function
REQ-016 Frame SHALL be: 0xA5 header; NCH motor bytes (bit7 = direction, bits[6:0] = magnitude, MSB-aligned to PWM_BITS); 1 dur byte; 1 checksum byte = XOR of all motor and dur bytes.
REQ-017 Parser FSM SHALL have states HUNT, PAYLOAD, CHECK; HUNT discards non-0xA5 bytes, PAYLOAD counts NCH+1 bytes, CHECK consumes the checksum and returns to HUNT.
REQ-018 On checksum byte accept SHALL, next cycle, assert tx_valid with 0x41 'A' (good, pushed), 0x4E 'N' (bad checksum, dropped) or 0x42 'B' (good but FIFO full, dropped).
REQ-019 rx_ready SHALL be low from tx_valid rise until the tx_valid & tx_ready cycle; tx_valid SHALL fall the cycle after.
REQ-020 Push SHALL occur in the same cycle tx_valid rises; fifo_count SHALL update the following cycle.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged; push to full SHALL be impossible by REQ-018.
REQ-022 Executor FSM SHALL have states IDLE, RUN; IDLE with FIFO non-empty SHALL pop and enter RUN next cycle, clearing PWM and duration counters.
REQ-023 In RUN, SHALL stay exactly dur*2^DUR_SHIFT cycles, then pulse cmd_done for one cycle and return to IDLE; back-to-back commands SHALL have one IDLE cycle between them.
REQ-024 A popped command with dur = 0 SHALL not enter RUN; it SHALL pulse cmd_done in the pop cycle + 1 with hbridge = 0.
REQ-025 PWM counter SHALL be free-running PWM_BITS wide in RUN, wrapping at 2^PWM_BITS-1 -> 0; wave_i = (mag_i > count); mag 0 SHALL give 0% duty and max mag SHALL give (2^PWM_BITS-1)/2^PWM_BITS duty.
REQ-026 hbridge pair SHALL be {wave,0} when dir=0, {0,wave} when dir=1, 00 when not in RUN.
REQ-027 busy SHALL equal (state == RUN).
REQ-028 stop SHALL, next cycle, force IDLE, hbridge = 0, fifo_count = 0, no cmd_done; parser and pending ack SHALL be unaffected; stop coinciding with a push SHALL discard that push.
REQ-029 stop held high SHALL keep the executor in IDLE and the FIFO empty.

Reset
REQ-030 reset low SHALL asynchronously set parser HUNT, executor IDLE, FIFO empty, counters 0, hbridge 0, tx_valid 0, tx_data 0x00, busy 0, cmd_done 0, rx_ready 1.
REQ-031 Reset mid-frame or mid-run SHALL discard all partial state; the first frame after release SHALL parse normally.

Structure
REQ-032 Package motor_pkg SHALL hold HDR (0xA5), ACK_OK/ACK_BAD/ACK_BUSY, and parser and executor state enums.
REQ-033 FIFO SHALL be a sub-module cmd_fifo (parameters WIDTH, DEPTH; push, pop, flush, full, empty, count).

Verification (NCH=2, PWM_BITS=7, DUR_SHIFT=2, DEPTH=4)
REQ-034 Good frame A5 40 C0 03 83 -> 'A'; RUN 12 cycles; ch0 {w,0} and ch1 {0,w} at 50% duty; one cmd_done.
REQ-035 Bad checksum A5 40 C0 03 00 -> 'N'; fifo_count stays 0; no RUN.
REQ-036 Five good frames with tx_ready always 1 while executor is held by stop=0 and dur=FF -> four 'A' then 'B'; fifo_count peaks at 4.
REQ-037 Garbage 00 11 then good frame -> bytes ignored, single 'A'; tx_ready low 5 cycles -> rx_ready low throughout and tx_data stable.
REQ-038 stop at cycle 5 of RUN with 2 queued -> hbridge 00 and fifo_count 0 next cycle; no cmd_done.
REQ-039 dur=00 frame -> 'A', cmd_done pulse, busy never high; reset asserted mid-RUN -> all outputs at reset values immediately.
